arb_rr2_stream: RTL



---
 rtl/arb_rr2_stream.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/arb_rr2_stream.sv
// Two-requester round-robin stream arbiter with burst-limited grants and a single registered output stage.
// Optional per-requester transfer counters (stat0/stat1) are enabled by defining ARB_RR2_STATS_EN.
module arb_rr2_stream #(
  parameter int N     = 18,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] in0_data,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [N-1:0] in1_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         grant,
  output logic         busy
`ifdef ARB_RR2_STATS_EN
  ,
  output logic [31:0]  stat0,
  output logic [31:0]  stat1
`endif
);

  localparam logic [7:0] BURST_C = 8'(BURST);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t       state_reg, state_next;
  logic         prio_reg;
  logic [7:0]   cnt_reg;
  logic [7:0]   cnt_inc;
  logic         owner;
  logic         can_accept;
  logic         cur_valid;
  logic         other_valid;
  logic [N-1:0] cur_data;
  logic         xfer;
  logic         rel_burst;
  logic         rel_idle;
  logic         rel;

  assign owner       = (state_reg == G1);
  assign can_accept  = !out_valid || out_ready;
  assign cur_valid   = owner ? in1_valid : in0_valid;
  assign other_valid = owner ? in0_valid : in1_valid;
  assign cur_data    = owner ? in1_data : in0_data;
  assign xfer        = busy && cur_valid && can_accept;
  assign cnt_inc     = cnt_reg + 8'd1;
  assign rel_burst   = xfer && (cnt_inc == BURST_C);
  assign rel_idle    = busy && !cur_valid;
  assign rel         = rel_burst || rel_idle;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (in0_valid && in1_valid) begin
          state_next = prio_reg ? G1 : G0;
        end else if (in0_valid) begin
          state_next = G0;
        end else if (in1_valid) begin
          state_next = G1;
        end
      end
      G0, G1: begin
        // A waiting peer always wins a release; a full burst with no peer re-arms the same grant.
        if (rel) begin
          if (other_valid) begin
            state_next = owner ? G0 : G1;
          end else if (rel_burst) begin
            state_next = state_reg;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_reg != IDLE);
    grant     = (state_reg == G1);
    in0_ready = (state_reg == G0) && can_accept;
    in1_ready = (state_reg == G1) && can_accept;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio_reg  <= 1'b0;
      cnt_reg   <= 8'd0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (rel) begin
        prio_reg <= !owner;
        cnt_reg  <= 8'd0;
      end else if (xfer) begin
        cnt_reg <= cnt_inc;
      end
      if (xfer) begin
        out_data  <= cur_data;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ARB_RR2_STATS_EN
  logic [1:0][31:0] stat_reg;
  logic [1:0]       take;

  assign take = {in1_valid && in1_ready, in0_valid && in0_ready};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_reg <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (take[i]) begin
          stat_reg[i] <= stat_reg[i] + 32'd1;
        end
      end
    end
  end

  assign stat0 = stat_reg[0];
  assign stat1 = stat_reg[1];
`endif

endmodule
